// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, schedule length and requantisation helper for FIR output stages
package fir_pkg;

  localparam int IN_W     = 33;
  localparam int OUT_W    = 16;
  localparam int IN_FRAC  = 31;
  localparam int OUT_FRAC = 15;
  localparam int PHASES   = 5;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] q;
  } rq_t;

  // sfix33_En31 -> sfix16_En15: add half an output LSB, drop 16 bits, clamp.
  function automatic rq_t sat_round(input logic [IN_W-1:0] in33);
    logic signed [IN_W:0] t;
    logic signed [IN_W:0] q;
    rq_t r;
    t = $signed({in33[IN_W-1], in33}) + 34'sd32768;
    q = t >>> (IN_FRAC - OUT_FRAC);
    if (q > 34'sd32767) begin
      r.sat = 1'b1;
      r.q   = 16'h7fff;
    end else if (q < -34'sd32768) begin
      r.sat = 1'b1;
      r.q   = 16'h8000;
    end else begin
      r.sat = 1'b0;
      r.q   = q[OUT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// rtl/fir_sample_fifo.sv - show-ahead sample FIFO with pointer-derived full/empty
module fir_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] last;
  logic         do_pop;
  logic         do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO keeps presenting the most recently popped word.
  assign head = empty ? last : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since reads are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Remember the word leaving the head so out_data holds it once empty.
  always_ff @(posedge clk) begin
    if (!reset)      last <= '0;
    else if (do_pop) last <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/fir_out_requant_fifo.sv
// rtl/fir_out_requant_fifo.sv - tracks filter phase, requantises each new sample and buffers it
module fir_out_requant_fifo
  import fir_pkg::*;
#(
  parameter int PHASES     = fir_pkg::PHASES,
  parameter int FIFO_DEPTH = 4,
  parameter int SATCNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_enable,
  input  logic [IN_W-1:0]     filter_in_data,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overflow,
  output logic [SATCNT_W-1:0] sat_count
);

  localparam logic [2:0] PH_LAST = 3'(PHASES - 1);

  logic [2:0] phase;
  logic       cap;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  rq_t        rq;

  assign cap       = (phase == 3'd0) && clk_enable;
  assign rq        = sat_round(filter_in_data);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Mirror of the filter's fold counter; the output register is stable in phase 0.
  always_ff @(posedge clk) begin
    if (!reset)              phase <= PH_LAST;
    else if (clk_enable) begin
      if (phase == PH_LAST)  phase <= 3'd0;
      else                   phase <= phase + 3'd1;
    end
  end

  // Sticky flag for a capture that found the FIFO full with no pop to make room.
  always_ff @(posedge clk) begin
    if (!reset)                            overflow <= 1'b0;
    else if (cap && fifo_full && !pop)     overflow <= 1'b1;
  end

  // Count clamped samples, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!reset)                                    sat_count <= '0;
    else if (cap && rq.sat && (sat_count != '1))   sat_count <= sat_count + 1'b1;
  end

  fir_sample_fifo #(
    .W     (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cap),
    .push_data (rq.q),
    .pop       (pop),
    .head      (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fir_out_requant_fifo.sv
// tb/tb_fir_out_requant_fifo.sv - randomized and directed bench for fir_out_requant_fifo
module tb_fir_out_requant_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic [32:0] filter_in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  sat_count;

  int compared   = 0;
  int mismatched = 0;

  int          en_cnt = 0;
  logic [15:0] mq[$];
  logic [15:0] m_last = 16'h0;
  logic        m_ovf = 1'b0;
  int          m_sat = 0;

  always #5 clk = ~clk;

  fir_out_requant_fifo dut (
    .clk            (clk),
    .reset          (reset),
    .clk_enable     (clk_enable),
    .filter_in_data (filter_in_data),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow       (overflow),
    .sat_count      (sat_count)
  );

  // Enabled edges since reset: first goes 4->0, so captures land on edges 2, 7, 12, ...
  function automatic int m_phase();
    return (en_cnt == 0) ? 4 : (en_cnt - 1) % 5;
  endfunction

  function automatic logic [16:0] ref_rq(input logic [32:0] d);
    longint v;
    longint q;
    v = longint'($signed(d));
    q = (v + 32768) >>> 16;
    if (q > 32767)  return {1'b1, 16'h7fff};
    if (q < -32768) return {1'b1, 16'h8000};
    return {1'b0, q[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic        cap;
    logic        pop;
    logic [16:0] r;
    @(posedge clk);
    if (!reset) begin
      mq.delete();
      m_last = 16'h0;
      m_ovf  = 1'b0;
      m_sat  = 0;
      en_cnt = 0;
    end else begin
      cap = clk_enable && (m_phase() == 0);
      pop = (mq.size() > 0) && out_ready;
      if (pop) m_last = mq.pop_front();
      if (cap) begin
        r = ref_rq(filter_in_data);
        if (r[16] && m_sat < 255) m_sat++;
        if (mq.size() < 4) mq.push_back(r[15:0]);
        else               m_ovf = 1'b1;
      end
      if (clk_enable) en_cnt++;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":valid"}, 32'(out_valid), 32'(mq.size() > 0));
    check({tag, ":data"}, 32'(out_data), 32'((mq.size() > 0) ? mq[0] : m_last));
    check({tag, ":ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ":satcnt"}, 32'(sat_count), 32'(m_sat));
    check({tag, ":phase"}, 32'(dut.phase), 32'(m_phase()));
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) begin
      step();
      check_all(tag);
    end
  endtask

  task automatic hold_check(input logic [32:0] d, input logic [15:0] exp, input string tag);
    filter_in_data = d;
    run(5, tag);
    check({tag, ":lit"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    logic [2:0] occ;
    int         guard;

    reset = 1'b0; clk_enable = 1'b1; out_ready = 1'b1; filter_in_data = '0;
    run(2, "reset");
    check("reset:valid_lit", 32'(out_valid), 0);
    check("reset:data_lit", 32'(out_data), 0);
    check("reset:phase_lit", 32'(dut.phase), 4);

    reset = 1'b1;
    run(2, "first");
    check("first:valid_lit", 32'(out_valid), 1);
    check("first:data_lit", 32'(out_data), 0);
    filter_in_data = 33'h0_4000_0000;
    run(13, "half");
    check("half:lit", 32'(out_data), 32'h4000);

    hold_check(33'h0_0000_8000, 16'h0001, "rnd_up");
    hold_check(33'h0_0000_7fff, 16'h0000, "rnd_dn");
    hold_check(33'h1_ffff_ffff, 16'h0000, "rnd_neg");
    check("rnd:satcnt_lit", 32'(sat_count), 0);
    hold_check(33'h0_ffff_ffff, 16'h7fff, "sat_pos");
    hold_check(33'h1_0000_0000, 16'h8000, "sat_neg");
    check("sat:satcnt_lit", 32'(sat_count), 2);

    repeat (300) begin
      if ($urandom_range(1))
        filter_in_data = {2'b01, 31'($urandom)};
      else
        filter_in_data = {2'b10, 31'($urandom)};
      run(5, "satrun");
    end
    check("satrun:satcnt_lit", 32'(sat_count), 255);

    reset = 1'b0;
    run(1, "rst2");
    reset = 1'b1;
    out_ready = 1'b0;
    repeat (6) begin
      filter_in_data = {1'($urandom), 32'($urandom)};
      run(5, "fill");
    end
    check("fill:valid_lit", 32'(out_valid), 1);
    check("fill:ovf_lit", 32'(overflow), 1);
    out_ready = 1'b1; clk_enable = 1'b0;
    run(6, "drain");
    check("drain:valid_lit", 32'(out_valid), 0);

    reset = 1'b0; clk_enable = 1'b1;
    run(1, "rst3");
    reset = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!(mq.size() == 4 && m_phase() == 0) && guard < 100) begin
      filter_in_data = {1'($urandom), 32'($urandom)};
      run(1, "prefill");
      guard++;
    end
    check("prefill:bound", 32'(guard < 100), 1);
    out_ready = 1'b1;
    filter_in_data = 33'h0_1234_5678;
    run(1, "pushpop");
    check("pushpop:ovf_lit", 32'(overflow), 0);
    occ = dut.u_fifo.wr_ptr - dut.u_fifo.rd_ptr;
    check("pushpop:occ", 32'(occ), 4);

    clk_enable = 1'b0;
    run(7, "noen");
    check("noen:valid_lit", 32'(out_valid), 0);

    reset = 1'b0;
    run(1, "rst4");
    check("rst4:valid_lit", 32'(out_valid), 0);
    check("rst4:ovf_lit", 32'(overflow), 0);
    check("rst4:satcnt_lit", 32'(sat_count), 0);
    check("rst4:phase_lit", 32'(dut.phase), 4);
    reset = 1'b1;

    repeat (400) begin
      clk_enable     = ($urandom_range(3) != 0);
      out_ready      = ($urandom_range(2) == 0);
      filter_in_data = {1'($urandom), 32'($urandom)};
      run(1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
